// File: rtl/eth_tx_arbiter.sv
// eth_tx_arbiter: round-robin arbiter that shares one Ethernet TX byte stream
// between NUM_REQ frame sources. The grant is held for a whole frame, an
// inter-frame gap is enforced after every frame end, and frames longer than
// MAX_BYTES are cut short. Any excess bytes are drained and discarded.
//
// Handshake: on every port, a byte moves on a rising clk edge when valid and
// ready are both 1. In XFER the granted source is wired straight through to
// the MAC, so req_ready[g] follows tx_ready. In DRAIN the arbiter accepts and
// discards the granted source's bytes on its own, until that source's last byte.
module eth_tx_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int IFG_CYCLES = 12,
    parameter int MAX_BYTES  = 1514,
    localparam int GW  = $clog2(NUM_REQ),
    localparam int CW  = $clog2(MAX_BYTES + 1),
    localparam int GCW = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ*8-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 tx_valid,
    output logic [7:0]           tx_data,
    output logic                 tx_last,
    input  logic                 tx_ready,
    output logic [GW-1:0]        grant_id,
    output logic                 busy,
    output logic                 frame_done,
    output logic                 oversize,
    output logic [1:0]           state_dbg
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_XFER  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    // With no gap configured, a frame end returns straight to IDLE
    localparam state_t   FRAME_END  = (IFG_CYCLES == 0) ? ST_IDLE : ST_GAP;
    localparam int       GAP_LOAD_I = (IFG_CYCLES > 0) ? IFG_CYCLES - 1 : 0;
    localparam logic [GCW-1:0] GAP_LOAD = GCW'(GAP_LOAD_I);

    state_t          state_q;
    logic [GW-1:0]   grant_q;
    logic [GW-1:0]   next_gnt_d;
    logic [GW-1:0]   cand;
    logic [CW-1:0]   byte_cnt_q;
    logic [GCW-1:0]  gap_cnt_q;
    logic            frame_done_q;
    logic            oversize_q;
    logic [7:0]      req_bytes [NUM_REQ];
    logic            sel_valid;
    logic            sel_last;
    logic            at_max;

    // Split the packed data bus into one byte lane per requester
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req_bytes[i] = req_data[8*i +: 8];
        end
    end

    assign sel_valid = req_valid[grant_q];
    assign sel_last  = req_last[grant_q];
    assign at_max    = (byte_cnt_q == CW'(MAX_BYTES - 1));

    // Round-robin pick. Scan from grant+1 upward; the nearest requester wins,
    // so the source that was just served comes last.
    always_comb begin
        next_gnt_d = grant_q;
        cand       = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = GW'((int'(grant_q) + k) % NUM_REQ);
            if (req_valid[cand]) begin
                next_gnt_d = cand;
            end
        end
    end

    // Combinational pass-through of the granted source in XFER; bytes are absorbed in DRAIN
    always_comb begin
        tx_valid  = 1'b0;
        tx_data   = 8'h00;
        tx_last   = 1'b0;
        req_ready = '0;
        case (state_q)
            ST_XFER: begin
                tx_valid           = sel_valid;
                tx_data            = req_bytes[grant_q];
                tx_last            = sel_last | at_max;
                req_ready[grant_q] = tx_ready;
            end
            ST_DRAIN: begin
                req_ready[grant_q] = 1'b1;
            end
            default: ;
        endcase
    end

    // Arbitration FSM, byte and gap counters, and the registered status pulses
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            grant_q      <= GW'(NUM_REQ - 1);
            byte_cnt_q   <= '0;
            gap_cnt_q    <= '0;
            frame_done_q <= 1'b0;
            oversize_q   <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            oversize_q   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (|req_valid) begin
                        grant_q    <= next_gnt_d;
                        byte_cnt_q <= '0;
                        state_q    <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    if (sel_valid && tx_ready) begin
                        byte_cnt_q <= byte_cnt_q + 1'b1;
                        if (sel_last) begin
                            frame_done_q <= 1'b1;
                            gap_cnt_q    <= GAP_LOAD;
                            state_q      <= FRAME_END;
                        end else if (at_max) begin
                            oversize_q <= 1'b1;
                            state_q    <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (sel_valid && sel_last) begin
                        frame_done_q <= 1'b1;
                        gap_cnt_q    <= GAP_LOAD;
                        state_q      <= FRAME_END;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt_q == '0) begin
                        state_q <= ST_IDLE;
                    end else begin
                        gap_cnt_q <= gap_cnt_q - 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign grant_id   = grant_q;
    assign busy       = (state_q != ST_IDLE);
    assign frame_done = frame_done_q;
    assign oversize   = oversize_q;
    assign state_dbg  = state_q;

endmodule
